viterbi_seq_ctrl: RTL and testbench
===================================

// Module: viterbi_seq_ctrl
//
// PURPOSE
//  Control sequencer for the Viterbi decoder core. It alternates the trellis-diagram
//  store between a fill phase (BMU/ACS write survivor states) and a traceback phase
//  (store read back in reverse by the traceback unit). It also handles end-of-data
//  and frame completion. Sits between the symbol source and the BMU/ACS/trellis/traceback datapath.
//
// PARAMETERS
//  TB_DEPTH  45  traceback depth in trellis stages (5*K, K=9); stages per fill window
//  ST_W      8   state index width (256 states)
//  CNT_W     6   stage counter width; must satisfy 2**CNT_W > TB_DEPTH
//
// PORTS
//  clk           in   1      clock; single clock domain
//  rst           in   1      reset, synchronous, active-high
//  i_start       in   1      start-of-frame pulse; honoured only in IDLE
//  i_sym_vld     in   1      input symbol valid; consumed only when o_sym_rdy=1
//  i_ood         in   1      out-of-data: last symbol of frame is present or already sent
//  i_best_st     in   ST_W   min-metric state from ACS (valid same cycle as last fill write)
//  i_td_full     in   1      trellis store full flag (cross-check only)
//  i_td_empty    in   1      trellis store empty flag (cross-check only)
//  o_sym_rdy     out  1      ready for a symbol (FILL state only)
//  o_en_bmu      out  1      branch metric unit enable
//  o_en_acs      out  1      add-compare-select enable
//  o_en_td       out  1      trellis store enable (write in FILL, read in TRACE)
//  o_td_ood      out  1      drives trellis store mode: 1 = read/traceback
//  o_en_tb       out  1      traceback unit enable
//  o_tb_st       out  ST_W   traceback start state, latched at FILL->TRACE
//  o_depth       out  CNT_W  current stage count
//  o_busy        out  1      high in any state except IDLE
//  o_done        out  1      one-cycle pulse at frame completion
//  o_err         out  1      sticky flag mismatch (only with VSC_CHK_EN)
//
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset: state=IDLE, depth=0, o_tb_st=0, frame_end=0. All outputs are 0.
//  - rst mid-frame aborts at the next edge. No partial traceback and no o_done.
//  - FSM states: IDLE, FILL, TRACE, DONE.
//  - IDLE:
//    - i_start=1 -> FILL; depth=0, frame_end=0.
//    - i_start is ignored in all other states.
//  - FILL:
//    - o_sym_rdy=1.
//    - o_en_bmu/o_en_acs/o_en_td = i_sym_vld (combinational, 0-cycle latency).
//    - Each accepted symbol: depth+1.
//  - FILL exit:
//    - depth==TB_DEPTH-1 with i_sym_vld=1 -> TRACE.
//    - i_ood=1 -> frame_end=1 -> TRACE; a symbol with i_sym_vld in the same cycle is
//      accepted first.
//    - On entry to TRACE: o_tb_st <= i_best_st, depth <= stages written.
//  - i_ood with depth==0 and no symbol accepted -> DONE directly; no traceback.
//  - TRACE:
//    - o_sym_rdy=0; o_td_ood=1; o_en_td=1; o_en_tb=1.
//    - depth decrements one per cycle; the last read cycle is depth==1.
//    - Then: frame_end ? DONE : FILL, with depth=0.
//  - i_sym_vld while o_sym_rdy=0 is not consumed; the source must hold it.
//  - DONE: o_done=1 for one cycle -> IDLE. o_busy falls in the same edge.
//  - Counters are unsigned CNT_W. depth never exceeds TB_DEPTH and never wraps below 0.
//  - Latency: TB_DEPTH accepted symbols + TB_DEPTH traceback cycles per full window.
//
// CONFIGURATION
//  VSC_CHK_EN defined:
//    - o_err sets and holds until rst on any of:
//      - i_td_full=1 in FILL with depth<TB_DEPTH-1;
//      - i_td_empty=1 in TRACE with depth>1;
//      - i_sym_vld=1 in TRACE.
//  VSC_CHK_EN undefined:
//    - o_err is tied to 0; i_td_full/i_td_empty are unused; no checker logic.
//
// TESTING
//  1. rst=1 for 2 cycles mid-FILL -> all outputs 0, state IDLE, o_done never pulses.
//  2. i_start, then 45 back-to-back i_sym_vld with i_best_st=8'hA5 on the 45th ->
//     TRACE entry, o_tb_st=8'hA5, o_en_tb high exactly 45 cycles, back to FILL.
//  3. i_start, 10 symbols, then i_ood=1 with i_sym_vld=1 on the 11th -> 11 TRACE cycles,
//     then DONE; o_done pulses once; o_busy falls next cycle.
//  4. i_start, then i_ood=1 immediately with no symbols -> DONE the next cycle; o_en_tb never asserts.
//  5. i_sym_vld held high through TRACE -> no o_en_bmu pulses and depth unchanged;
//     o_err=1 only with VSC_CHK_EN.
//  6. i_start pulsed during FILL/TRACE -> ignored; i_td_full=1 at depth=4 with VSC_CHK_EN -> o_err=1, sticky.

Source files
------------

// File: rtl/viterbi_seq_ctrl.sv
// Viterbi decoder control sequencer: alternates trellis store fill and traceback windows.
// Optional flag cross-checker enabled with `define VSC_CHK_EN.
module viterbi_seq_ctrl #(
  parameter int TB_DEPTH = 45,
  parameter int ST_W     = 8,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_sym_vld,
  input  logic             i_ood,
  input  logic [ST_W-1:0]  i_best_st,
  input  logic             i_td_full,
  input  logic             i_td_empty,
  output logic             o_sym_rdy,
  output logic             o_en_bmu,
  output logic             o_en_acs,
  output logic             o_en_td,
  output logic             o_td_ood,
  output logic             o_en_tb,
  output logic [ST_W-1:0]  o_tb_st,
  output logic [CNT_W-1:0] o_depth,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  // state   | meaning
  // IDLE    | waiting for i_start
  // FILL    | accepting symbols, BMU/ACS writing survivors to the store
  // TRACE   | store read back in reverse by the traceback unit
  // DONE    | one-cycle frame completion pulse
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_TRACE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(TB_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_WIN  = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             frame_end_q, frame_end_d;
  logic [ST_W-1:0]  tb_st_q, tb_st_d;
  logic [ST_W-1:0]  best_q, best_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      frame_end_q <= 1'b0;
      tb_st_q     <= '0;
      best_q      <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      frame_end_q <= frame_end_d;
      tb_st_q     <= tb_st_d;
      best_q      <= best_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    frame_end_d = frame_end_q;
    tb_st_d     = tb_st_q;
    best_d      = best_q;
    o_sym_rdy   = 1'b0;
    o_en_bmu    = 1'b0;
    o_en_acs    = 1'b0;
    o_en_td     = 1'b0;
    o_td_ood    = 1'b0;
    o_en_tb     = 1'b0;
    o_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_FILL;
          depth_d     = '0;
          frame_end_d = 1'b0;
          best_d      = '0;
        end
      end

      S_FILL: begin
        o_sym_rdy = 1'b1;
        o_en_bmu  = i_sym_vld;
        o_en_acs  = i_sym_vld;
        o_en_td   = i_sym_vld;
        if (i_sym_vld) best_d = i_best_st;
        if (i_sym_vld && depth_q == LAST_FILL) begin
          state_d     = S_TRACE;
          depth_d     = FULL_WIN;
          tb_st_d     = i_best_st;
          frame_end_d = i_ood;
        end else if (i_ood) begin
          frame_end_d = 1'b1;
          if (i_sym_vld) begin
            state_d = S_TRACE;
            depth_d = depth_q + ONE;
            tb_st_d = i_best_st;
          end else if (depth_q == '0) begin
            state_d = S_DONE;
          end else begin
            // last symbol went in on an earlier cycle; its best state was kept
            state_d = S_TRACE;
            tb_st_d = best_q;
          end
        end else if (i_sym_vld) begin
          depth_d = depth_q + ONE;
        end
      end

      S_TRACE: begin
        o_td_ood = 1'b1;
        o_en_td  = 1'b1;
        o_en_tb  = 1'b1;
        if (depth_q <= ONE) begin
          depth_d = '0;
          state_d = frame_end_q ? S_DONE : S_FILL;
        end else begin
          depth_d = depth_q - ONE;
        end
      end

      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_depth = depth_q;
  assign o_tb_st = tb_st_q;

`ifdef VSC_CHK_EN
  logic err_q;
  logic err_hit;

  always_comb begin
    err_hit = 1'b0;
    if (state_q == S_FILL && i_td_full && depth_q < LAST_FILL) err_hit = 1'b1;
    if (state_q == S_TRACE && i_td_empty && depth_q > ONE)     err_hit = 1'b1;
    if (state_q == S_TRACE && i_sym_vld)                        err_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | err_hit;
  end

  assign o_err = err_q;
`else
  logic unused_flags;
  assign unused_flags = i_td_full ^ i_td_empty;
  assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// Directed bench for viterbi_seq_ctrl: stimulus pushes expected trace/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_viterbi_seq_ctrl;
  localparam int TB_DEPTH = 45;
  localparam int ST_W     = 8;
  localparam int CNT_W    = 6;
`ifdef VSC_CHK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_sym_vld, i_ood, i_td_full, i_td_empty;
  logic [ST_W-1:0]  i_best_st;
  logic             o_sym_rdy, o_en_bmu, o_en_acs, o_en_td, o_td_ood, o_en_tb;
  logic [ST_W-1:0]  o_tb_st;
  logic [CNT_W-1:0] o_depth;
  logic             o_busy, o_done, o_err;

  viterbi_seq_ctrl #(.TB_DEPTH(TB_DEPTH), .ST_W(ST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_sym_vld(i_sym_vld), .i_ood(i_ood),
    .i_best_st(i_best_st), .i_td_full(i_td_full), .i_td_empty(i_td_empty),
    .o_sym_rdy(o_sym_rdy), .o_en_bmu(o_en_bmu), .o_en_acs(o_en_acs), .o_en_td(o_en_td),
    .o_td_ood(o_td_ood), .o_en_tb(o_en_tb), .o_tb_st(o_tb_st), .o_depth(o_depth),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef enum int {E_TBST, E_DEPTH, E_TLEN, E_DONE} ekind_t;
  typedef struct {
    ekind_t kind;
    int     val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input ekind_t k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input ekind_t k, input int act);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected_%s: got %0d with nothing expected", k.name(), act);
    end else begin
      e = sb.pop_front();
      if (e.kind != k) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_order: got event %s expected event %s", k.name(), e.kind.name());
      end else begin
        check({"sb_", k.name()}, act, e.val);
      end
    end
  endtask

  // monitor: trace-window entry/length and done pulses
  initial begin
    bit prev_tb   = 1'b0;
    bit busy_chk  = 1'b0;
    int run       = 0;
    forever begin
      @(negedge clk);
      if (busy_chk) begin
        check("busy_after_done", int'(o_busy), 0);
        busy_chk = 1'b0;
      end
      if (o_en_tb && !prev_tb) begin
        sb_check(E_TBST, int'(o_tb_st));
        sb_check(E_DEPTH, int'(o_depth));
        run = 1;
      end else if (o_en_tb) begin
        run++;
      end else if (prev_tb) begin
        sb_check(E_TLEN, run);
      end
      if (o_done) begin
        sb_check(E_DONE, int'(o_busy));
        busy_chk = 1'b1;
      end
      prev_tb = o_en_tb;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_start = 1'b0; i_sym_vld = 1'b0; i_ood = 1'b0;
    i_td_full = 1'b0; i_td_empty = 1'b0; i_best_st = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic send_syms(input int n, input logic [ST_W-1:0] best_last);
    for (int i = 0; i < n; i++) begin
      i_sym_vld = 1'b1;
      i_best_st = (i == n - 1) ? best_last : 8'h11;
      step();
    end
    i_sym_vld = 1'b0;
  endtask

  task automatic wait_rdy(input string name, input int max_cyc);
    int n = 0;
    while (!o_sym_rdy && n < max_cyc) begin
      step();
      n++;
    end
    check(name, int'(o_sym_rdy), 1);
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n = 0;
    while (!o_done && n < max_cyc) begin
      step();
      n++;
    end
    check(name, int'(o_done), 1);
  endtask

  function automatic int out_vec();
    return int'({o_sym_rdy, o_en_bmu, o_en_acs, o_en_td, o_td_ood, o_en_tb,
                 o_tb_st, o_depth, o_busy, o_done, o_err});
  endfunction

  initial begin
    int bmu_bad;
    int dep_bad;

    // reset state
    do_reset();
    check("reset_outputs", out_vec(), 0);

    // 1: reset mid-FILL aborts with no done
    start_frame();
    send_syms(5, 8'h22);
    check("t1_depth_before_rst", int'(o_depth), 5);
    do_reset();
    check("t1_rst_outputs", out_vec(), 0);
    for (int i = 0; i < 5; i++) step();
    check("t1_idle_busy", int'(o_busy), 0);

    // 2: full window, back to FILL
    do_reset();
    start_frame();
    push(E_TBST, 8'hA5); push(E_DEPTH, TB_DEPTH); push(E_TLEN, TB_DEPTH);
    i_sym_vld = 1'b1;
    #1;
    check("t2_en_comb", int'({o_en_bmu, o_en_acs, o_en_td}), 7);
    send_syms(10, 8'h11);
    check("t2_depth10", int'(o_depth), 10);
    send_syms(35, 8'hA5);
    check("t2_trace_mode", int'({o_sym_rdy, o_td_ood, o_en_td}), 3);
    wait_rdy("t2_back_to_fill", 100);
    check("t2_fill_depth0", int'(o_depth), 0);
    check("t2_still_busy", int'(o_busy), 1);

    // 3: short frame with ood on 11th symbol
    do_reset();
    start_frame();
    push(E_TBST, 8'h3C); push(E_DEPTH, 11); push(E_TLEN, 11); push(E_DONE, 1);
    send_syms(10, 8'h11);
    i_sym_vld = 1'b1; i_ood = 1'b1; i_best_st = 8'h3C;
    step();
    i_sym_vld = 1'b0; i_ood = 1'b0;
    wait_done("t3_done", 50);
    step();
    check("t3_done_one_cycle", int'(o_done), 0);
    check("t3_busy_fell", int'(o_busy), 0);

    // 4: ood with no symbols goes straight to DONE
    do_reset();
    start_frame();
    push(E_DONE, 1);
    i_ood = 1'b1;
    step();
    i_ood = 1'b0;
    check("t4_done_next", int'(o_done), 1);
    step();
    step();
    check("t4_idle", int'(o_busy), 0);

    // 5: symbol valid held through TRACE
    do_reset();
    start_frame();
    push(E_TBST, 8'h77); push(E_DEPTH, TB_DEPTH); push(E_TLEN, TB_DEPTH);
    send_syms(44, 8'h11);
    i_sym_vld = 1'b1; i_best_st = 8'h77;
    step();
    bmu_bad = 0;
    dep_bad = 0;
    for (int i = 0; i < TB_DEPTH; i++) begin
      if (o_en_bmu || o_en_acs || o_sym_rdy) bmu_bad++;
      if (int'(o_depth) != TB_DEPTH - i) dep_bad++;
      step();
    end
    check("t5_no_bmu_in_trace", bmu_bad, 0);
    check("t5_trace_depth", dep_bad, 0);
    check("t5_fill_depth0", int'(o_depth), 0);
    check("t5_err", int'(o_err), EXP_ERR);
    i_sym_vld = 1'b0;
    step();
    check("t5_err_sticky", int'(o_err), EXP_ERR);

    // 6: start ignored while busy; full flag early
    do_reset();
    start_frame();
    send_syms(4, 8'h11);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("t6_start_ignored_depth", int'(o_depth), 4);
    check("t6_start_ignored_rdy", int'(o_sym_rdy), 1);
    check("t6_err_clear", int'(o_err), 0);
    i_td_full = 1'b1;
    step();
    i_td_full = 1'b0;
    check("t6_err_full", int'(o_err), EXP_ERR);
    step();
    step();
    check("t6_err_sticky", int'(o_err), EXP_ERR);
    push(E_TBST, 8'h5A); push(E_DEPTH, TB_DEPTH); push(E_TLEN, TB_DEPTH);
    send_syms(40, 8'h11);
    send_syms(1, 8'h5A);
    for (int i = 0; i < 10; i++) step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_rdy("t6_back_to_fill", 100);
    check("t6_fill_depth0", int'(o_depth), 0);

    for (int i = 0; i < 4; i++) step();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
